counter_checker: RTL



---
 rtl/counter_checker_if.sv | 27 ++
 rtl/counter_checker.sv | 119 +++++++++++
 2 files changed

// File: rtl/counter_checker_if.sv
// Bus between a counter-stream source and the counter_checker monitor:
// sampled stream plus strobe/clear in, lock/error/wrap status out.
interface counter_checker_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_WIDTH = 8
);
  logic [WIDTH-1:0]     data_in;
  logic                 data_valid;
  logic                 clear;
  logic                 locked;
  logic                 err_pulse;
  logic                 wrap_pulse;
  logic [ERR_WIDTH-1:0] err_count;
  logic [WIDTH-1:0]     last_value;

  // stream source / bench side
  modport master (
    output data_in, data_valid, clear,
    input  locked, err_pulse, wrap_pulse, err_count, last_value
  );

  // checker side
  modport slave (
    input  data_in, data_valid, clear,
    output locked, err_pulse, wrap_pulse, err_count, last_value
  );
endinterface

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running counter stream. Locks after
// LOCK_COUNT consecutive +1 steps, then flags every sample that breaks the
// sequence. A mismatch still advances the expected value, so one corrupted
// sample costs exactly one error; LOSS_COUNT back-to-back misses drop lock.
module counter_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_checker_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  localparam logic [3:0]           LOCK_C  = 4'(LOCK_COUNT);
  localparam logic [3:0]           LOSS_C  = 4'(LOSS_COUNT);
  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);

  state_t               state_q;
  logic [WIDTH-1:0]     expected_q;
  logic [3:0]           match_cnt_q;
  logic [3:0]           miss_cnt_q;
  logic                 locked_q;
  logic                 err_pulse_q;
  logic                 wrap_pulse_q;
  logic [ERR_WIDTH-1:0] err_count_q;
  logic [WIDTH-1:0]     last_value_q;

  logic [WIDTH-1:0]     samp_inc;    // sample + 1, mod 2^WIDTH
  logic [WIDTH-1:0]     exp_inc;     // expected + 1, mod 2^WIDTH
  logic                 hit;
  logic [3:0]           match_nxt;
  logic [3:0]           miss_nxt;
  logic                 err_sat;

  // next-value helpers shared by the FSM
  always_comb begin
    samp_inc  = bus.data_in + ONE;
    exp_inc   = expected_q + ONE;
    hit       = (bus.data_in == expected_q);
    match_nxt = match_cnt_q + 4'd1;
    miss_nxt  = miss_cnt_q + 4'd1;
    err_sat   = (err_count_q == {ERR_WIDTH{1'b1}});
  end

  // lock FSM with registered status outputs; idle cycles change nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      expected_q   <= '0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
      last_value_q <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (bus.clear) err_count_q <= '0;
      if (bus.data_valid) begin
        last_value_q <= bus.data_in;
        case (state_q)
          IDLE: begin
            expected_q  <= samp_inc;
            match_cnt_q <= '0;
            state_q     <= ACQUIRE;
          end
          ACQUIRE: begin
            expected_q <= samp_inc;
            if (hit) begin
              match_cnt_q <= match_nxt;
              if (match_nxt == LOCK_C) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else begin
              match_cnt_q <= '0;
            end
          end
          LOCKED: begin
            // timeline advances on match and mismatch alike
            expected_q <= exp_inc;
            if (hit) begin
              miss_cnt_q   <= '0;
              wrap_pulse_q <= (bus.data_in == '0);
            end else begin
              err_pulse_q <= 1'b1;
              // clear wins over a same-cycle increment
              if (!bus.clear && !err_sat) err_count_q <= err_count_q + ERR_ONE;
              miss_cnt_q <= miss_nxt;
              if (miss_nxt == LOSS_C) begin
                state_q     <= ACQUIRE;
                locked_q    <= 1'b0;
                expected_q  <= samp_inc;
                match_cnt_q <= '0;
                miss_cnt_q  <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.err_count  = err_count_q;
  assign bus.last_value = last_value_q;

endmodule
